// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encoding and saturating counter helper for the trace buffer
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Increment that sticks at lim; callers pass their all-ones value as lim.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] lim);
    return (v == lim) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through FIFO with flush and explicit occupancy count
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  // Gated so the data port reads zero whenever nothing is stored (e.g. out of reset).
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - armed capture of the CPU debug word into a drainable trace FIFO
module debug_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [DATA_WIDTH-1:0]   debug,
  output logic [DATA_WIDTH-1:0]   outData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    capturing,
  output logic                    done,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    sampleCount,
  output logic [CNT_WIDTH-1:0]    dropCount,
  output logic [$clog2(DEPTH):0]  level
);

  localparam logic [63:0] CNT_MAX = 64'({CNT_WIDTH{1'b1}});

  state_t               state, state_next;
  logic                 push;
  logic                 flush;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_WIDTH-1:0] sample_inc;
  logic [CNT_WIDTH-1:0] drop_inc;

  assign outValid   = !fifo_empty;
  assign pop        = outValid && outReady;
  assign capturing  = (state == CAPTURE);
  assign done       = (state == DONE);
  assign sample_inc = CNT_WIDTH'(sat_inc(64'(sampleCount), CNT_MAX));
  assign drop_inc   = CNT_WIDTH'(sat_inc(64'(dropCount), CNT_MAX));

  trace_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(debug),
    .rdata(outData),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          flush      = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_next = DONE;
        end else begin
          push = 1'b1;
          // The sample that reaches the limit is still taken; the run ends after it.
          if (MAX_CYCLES != 0 && 32'(sample_inc) == MAX_CYCLES) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampleCount <= '0;
      dropCount   <= '0;
      overflow    <= 1'b0;
    end else if (flush) begin
      sampleCount <= '0;
      dropCount   <= '0;
      overflow    <= 1'b0;
    end else if (push) begin
      sampleCount <= sample_inc;
      if (fifo_full && !pop) begin
        dropCount <= drop_inc;
        overflow  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb/tb_debug_trace_buffer.sv - scoreboard bench for debug_trace_buffer against a queue-based model
module tb_debug_trace_buffer;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int DA = 4;
  localparam int MA = 10;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_start, a_stop, a_ready;
  logic [DW-1:0] a_debug, a_data;
  logic          a_valid, a_capt, a_done, a_ovf;
  logic [CW-1:0] a_scnt, a_dcnt;
  logic [2:0]    a_level;

  logic          b_start, b_stop, b_ready;
  logic [DW-1:0] b_debug, b_data;
  logic          b_valid, b_capt, b_done, b_ovf;
  logic [CW-1:0] b_scnt, b_dcnt;
  logic [4:0]    b_level;

  debug_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DA), .MAX_CYCLES(MA), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .debug(a_debug),
    .outData(a_data), .outValid(a_valid), .outReady(a_ready), .capturing(a_capt),
    .done(a_done), .overflow(a_ovf), .sampleCount(a_scnt), .dropCount(a_dcnt), .level(a_level)
  );

  debug_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DB), .MAX_CYCLES(0), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .debug(b_debug),
    .outData(b_data), .outValid(b_valid), .outReady(b_ready), .capturing(b_capt),
    .done(b_done), .overflow(b_ovf), .sampleCount(b_scnt), .dropCount(b_dcnt), .level(b_level)
  );

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model of dut_a: run phase, stored words as a queue, and the run counters.
  typedef enum {M_IDLE, M_CAP, M_DONE} mphase_t;
  mphase_t       m_ph;
  int            m_cnt, m_samp, m_drop;
  bit            m_ovf, m_pop;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = M_IDLE; m_cnt = 0; m_samp = 0; m_drop = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      m_pop = (m_cnt > 0) && a_ready;
      if (m_ph != M_CAP && a_start) begin
        m_ph = M_CAP; m_cnt = 0; m_samp = 0; m_drop = 0; m_ovf = 0;
        exp_q.delete();
      end else begin
        if (m_pop) m_cnt--;
        if (m_ph == M_CAP) begin
          if (a_stop) begin
            m_ph = M_DONE;
          end else begin
            if (m_samp < 65535) m_samp++;
            if (m_cnt < DA) begin
              m_cnt++;
              exp_q.push_back(a_debug);
            end else begin
              if (m_drop < 65535) m_drop++;
              m_ovf = 1;
            end
            if (m_samp == MA) m_ph = M_DONE;
          end
        end
      end
    end
  end

  // Monitor: compares status every cycle and retires the expected head on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 64'(a_valid), 64'(m_cnt > 0));
      check("level", 64'(a_level), 64'(m_cnt));
      check("capturing", 64'(a_capt), 64'(m_ph == M_CAP));
      check("done", 64'(a_done), 64'(m_ph == M_DONE));
      check("overflow", 64'(a_ovf), 64'(m_ovf));
      check("sampleCount", 64'(a_scnt), 64'(m_samp));
      check("dropCount", 64'(a_dcnt), 64'(m_drop));
      if (a_valid === 1'b1 && a_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 64'(a_data), 64'hDEAD_0000_0000);
        end else begin
          check("data", 64'(a_data), 64'(exp_q[0]));
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      a_debug = DW'(cyc);
      tick();
    end
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic zero_a(input string tag);
    check({tag, "_a_valid"}, 64'(a_valid), 64'd0);
    check({tag, "_a_data"}, 64'(a_data), 64'd0);
    check({tag, "_a_capt"}, 64'(a_capt), 64'd0);
    check({tag, "_a_done"}, 64'(a_done), 64'd0);
    check({tag, "_a_ovf"}, 64'(a_ovf), 64'd0);
    check({tag, "_a_scnt"}, 64'(a_scnt), 64'd0);
    check({tag, "_a_dcnt"}, 64'(a_dcnt), 64'd0);
    check({tag, "_a_level"}, 64'(a_level), 64'd0);
  endtask

  task automatic zero_b(input string tag);
    check({tag, "_b_valid"}, 64'(b_valid), 64'd0);
    check({tag, "_b_data"}, 64'(b_data), 64'd0);
    check({tag, "_b_capt"}, 64'(b_capt), 64'd0);
    check({tag, "_b_done"}, 64'(b_done), 64'd0);
    check({tag, "_b_ovf"}, 64'(b_ovf), 64'd0);
    check({tag, "_b_scnt"}, 64'(b_scnt), 64'd0);
    check({tag, "_b_dcnt"}, 64'(b_dcnt), 64'd0);
    check({tag, "_b_level"}, 64'(b_level), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int p0, n;
    reset = 1'b1;
    a_start = 0; a_stop = 0; a_ready = 0; a_debug = '0;
    b_start = 0; b_stop = 0; b_ready = 0; b_debug = '0;
    mon_en = 1'b1;
    tick(); tick();
    zero_a("reset");
    zero_b("reset");
    reset = 1'b0;
    tick();

    // Continuous drain with ready held: ten samples, in order, then DONE.
    a_ready = 1'b1;
    p0 = pops;
    start_a();
    run(14);
    check("t1_pops", 64'(pops - p0), 64'd10);
    check("t1_done", 64'(a_done), 64'd1);
    check("t1_scnt", 64'(a_scnt), 64'd10);
    check("t1_dcnt", 64'(a_dcnt), 64'd0);

    // No consumer: four stored, six dropped; draining returns the first four.
    a_ready = 1'b0;
    start_a();
    run(12);
    check("t2_level", 64'(a_level), 64'd4);
    check("t2_dcnt", 64'(a_dcnt), 64'd6);
    check("t2_ovf", 64'(a_ovf), 64'd1);
    p0 = pops;
    a_ready = 1'b1;
    run(6);
    check("t2_drain", 64'(pops - p0), 64'd4);

    // Fill to full, then push and pop together for the rest of the run.
    a_ready = 1'b0;
    start_a();
    run(4);
    check("t3_full", 64'(a_level), 64'd4);
    a_ready = 1'b1;
    n = 0;
    while (a_capt && n < 20) begin
      run(1);
      check("t3_level", 64'(a_level), 64'd4);
      n++;
    end
    check("t3_ended", 64'(a_done), 64'd1);
    check("t3_dcnt", 64'(a_dcnt), 64'd0);
    run(6);

    // Restart from DONE with three unread words: they are flushed.
    a_ready = 1'b0;
    start_a();
    for (int i = 0; i < 3; i++) begin a_debug = 32'hA000 + i; tick(); end
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    check("t6_level_before", 64'(a_level), 64'd3);
    start_a();
    check("t6_level", 64'(a_level), 64'd0);
    check("t6_capt", 64'(a_capt), 64'd1);
    check("t6_valid", 64'(a_valid), 64'd0);
    a_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin a_debug = 32'hB000 + i; tick(); end

    // Unlimited run ended by stop on the fourth CAPTURE cycle.
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 3; i++) begin b_debug = 100 + i; tick(); end
    b_stop = 1'b1; tick(); b_stop = 1'b0;
    check("t4_scnt", 64'(b_scnt), 64'd3);
    check("t4_done", 64'(b_done), 64'd1);
    check("t4_level", 64'(b_level), 64'd3);
    b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_valid", 64'(b_valid), 64'd1);
      check("t4_data", 64'(b_data), 64'(100 + i));
      tick();
    end
    check("t4_empty", 64'(b_valid), 64'd0);
    b_ready = 1'b0;

    // Asynchronous reset with five words stored, then a clean restart.
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 5; i++) begin b_debug = 200 + i; tick(); end
    check("t5_level_before", 64'(b_level), 64'd5);
    reset = 1'b1;
    #1;
    zero_b("t5_async");
    tick();
    reset = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("t5_restart_level", 64'(b_level), 64'd0);
    check("t5_restart_scnt", 64'(b_scnt), 64'd0);
    b_debug = 32'h5A5A; tick();
    check("t5_new_data", 64'(b_data), 64'h5A5A);
    check("t5_new_scnt", 64'(b_scnt), 64'd1);
    b_stop = 1'b1; tick(); b_stop = 1'b0;

    // Randomized traffic with occasional mid-run resets.
    for (int c = 0; c < 400; c++) begin
      a_start = ($urandom_range(7) == 0);
      a_stop  = ($urandom_range(9) == 0);
      a_ready = 1'($urandom_range(1));
      a_debug = $urandom;
      if ($urandom_range(99) == 0) begin
        reset = 1'b1;
        #1;
        zero_a("rand_reset");
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    a_start = 0; a_stop = 0;

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
